// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiply/divide op encodings and the sequencer state enum.
// The multicycle control unit imports the same op constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE,
    ST_DZERO
  } mds_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mds_signfix.sv
// Conditional two's-complement negate of an N-bit value; used for operand
// magnitudes on the way in and for result signs on the way out.
module mds_signfix #(
  parameter int N = 32
) (
  input  logic         neg_i,
  input  logic [N-1:0] val_i,
  output logic [N-1:0] val_o
);

  assign val_o = neg_i ? ({N{1'b0}} - val_i) : val_i;

endmodule

// File: rtl/mult_div_seq.sv
// Iterative multiply/divide sequencer with HI/LO result registers, signed and
// unsigned ops, optional multiply early-out and a divide-by-zero pulse.
module mult_div_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef struct packed {
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
  } mul_t;

  typedef struct packed {
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
  } div_t;

  function automatic mul_t mul_step(input logic [2*WIDTH-1:0] prod,
                                    input logic [2*WIDTH-1:0] mcand,
                                    input logic [WIDTH-1:0]   mplier);
    mul_t r;
    r.prod   = mplier[0] ? (prod + mcand) : prod;
    r.mcand  = mcand << 1;
    r.mplier = mplier >> 1;
    return r;
  endfunction

  // Restoring step: shift the next dividend bit into the remainder and subtract if it fits.
  function automatic div_t div_step(input logic [WIDTH-1:0] rem,
                                    input logic [WIDTH-1:0] quo,
                                    input logic [WIDTH-1:0] dvsr);
    div_t           r;
    logic [WIDTH:0] trial;
    logic           fits;
    trial = {rem, quo[WIDTH-1]};
    fits  = (trial >= {1'b0, dvsr});
    r.rem = fits ? (trial[WIDTH-1:0] - dvsr) : trial[WIDTH-1:0];
    r.quo = {quo[WIDTH-2:0], fits};
    return r;
  endfunction

  mds_state_e         state_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               sign_res_q, sign_rem_q;
  logic [2*WIDTH-1:0] prod_q, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   rem_q, quo_q, dvsr_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, done_q, dz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               sa, sb, in_prep;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  mul_t               mul_nx;
  div_t               div_nx;
  logic               mul_early;

  assign sa      = op_is_signed(op_q) & a_q[WIDTH-1];
  assign sb      = op_is_signed(op_q) & b_q[WIDTH-1];
  assign in_prep = (state_q == ST_PREP);

  mds_signfix #(.N(WIDTH)) u_abs_a (.neg_i(sa), .val_i(a_q), .val_o(mag_a));
  mds_signfix #(.N(WIDTH)) u_abs_b (.neg_i(sb), .val_i(b_q), .val_o(mag_b));

  mds_signfix #(.N(2*WIDTH)) u_fix_prod (.neg_i(sign_res_q), .val_i(prod_q), .val_o(prod_fix));
  mds_signfix #(.N(WIDTH))   u_fix_quo  (.neg_i(sign_res_q), .val_i(quo_q),  .val_o(quo_fix));
  mds_signfix #(.N(WIDTH))   u_fix_rem  (.neg_i(sign_rem_q), .val_i(rem_q),  .val_o(rem_fix));

  // PREP already performs the first iteration on the fresh magnitudes, so
  // WIDTH iterations plus FIX complete within WIDTH+2 edges of acceptance.
  always_comb begin
    mul_nx    = in_prep ? mul_step('0, {{WIDTH{1'b0}}, mag_a}, mag_b)
                        : mul_step(prod_q, mcand_q, mplier_q);
    div_nx    = in_prep ? div_step('0, mag_a, mag_b)
                        : div_step(rem_q, quo_q, dvsr_q);
    mul_early = EARLY_OUT && (mul_nx.mplier == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sign_res_q <= 1'b0;
      sign_rem_q <= 1'b0;
      prod_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            busy_q  <= 1'b1;
            state_q <= ST_PREP;
          end
        end
        ST_PREP: begin
          sign_res_q <= sa ^ sb;
          sign_rem_q <= sa;
          cnt_q      <= CW'(1);
          if (op_is_div(op_q)) begin
            if (b_q == '0) begin
              done_q  <= 1'b1;
              dz_q    <= 1'b1;
              state_q <= ST_DZERO;
            end else begin
              rem_q   <= div_nx.rem;
              quo_q   <= div_nx.quo;
              dvsr_q  <= mag_b;
              state_q <= ST_DIV;
            end
          end else begin
            prod_q   <= mul_nx.prod;
            mcand_q  <= mul_nx.mcand;
            mplier_q <= mul_nx.mplier;
            state_q  <= mul_early ? ST_FIX : ST_MUL;
          end
        end
        ST_MUL: begin
          prod_q   <= mul_nx.prod;
          mcand_q  <= mul_nx.mcand;
          mplier_q <= mul_nx.mplier;
          cnt_q    <= cnt_q + CW'(1);
          if ((cnt_q == LAST) || mul_early) state_q <= ST_FIX;
        end
        ST_DIV: begin
          rem_q <= div_nx.rem;
          quo_q <= div_nx.quo;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) state_q <= ST_FIX;
        end
        ST_FIX: begin
          if (op_is_div(op_q)) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE, ST_DZERO: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
